// File: rtl/router_merge.sv
// Four-source merge into a single registered output slot with a one-hot grant per cycle.
// Define ROUTER_MERGE_RR_EN for round-robin arbitration; the default build uses fixed priority (source 0 highest).
module router_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic                  din_en0,
  input  logic                  din_en1,
  input  logic                  din_en2,
  input  logic                  din_en3,
  output logic                  din_ready0,
  output logic                  din_ready1,
  output logic                  din_ready2,
  output logic                  din_ready3,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_en,
  output logic [1:0]            dout_addr,
  input  logic                  dout_ready
);

  logic [3:0]            req;
  logic [DATA_WIDTH-1:0] din_arr [4];

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_en_q, dout_en_d;
  logic [1:0]            dout_addr_q, dout_addr_d;
  logic [1:0]            ptr_q, ptr_d;

  logic                  slot_free;
  logic                  grant;
  logic [3:0]            gnt_oh;
  logic [1:0]            gnt_idx;
  logic                  found;
  logic [1:0]            cand;
  logic [3:0]            ready_vec;

  assign req        = {din_en3, din_en2, din_en1, din_en0};
  assign din_arr[0] = din0;
  assign din_arr[1] = din1;
  assign din_arr[2] = din2;
  assign din_arr[3] = din3;

  assign slot_free = ~dout_en_q | dout_ready;

  // Scan from the pointer upward so source ptr_q wins ties; data values never enter this path.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req[cand]) begin
        gnt_oh[cand] = 1'b1;
        gnt_idx      = cand;
        found        = 1'b1;
      end
    end
  end

  // Gating with resetn keeps every ready low while the slot is held in reset.
  assign grant     = resetn & slot_free & found;
  assign ready_vec = grant ? gnt_oh : 4'b0000;

  assign din_ready0 = ready_vec[0];
  assign din_ready1 = ready_vec[1];
  assign din_ready2 = ready_vec[2];
  assign din_ready3 = ready_vec[3];

  always_comb begin
    dout_d      = dout_q;
    dout_en_d   = dout_en_q;
    dout_addr_d = dout_addr_q;
    if (grant) begin
      dout_d      = din_arr[gnt_idx];
      dout_en_d   = 1'b1;
      dout_addr_d = gnt_idx;
    end else if (dout_en_q && dout_ready) begin
      dout_d      = '0;
      dout_en_d   = 1'b0;
      dout_addr_d = '0;
    end
  end

`ifdef ROUTER_MERGE_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = gnt_idx + 2'd1;
    end
  end
`else
  always_comb begin
    ptr_d = 2'd0;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_q      <= '0;
      dout_en_q   <= 1'b0;
      dout_addr_q <= '0;
      ptr_q       <= '0;
    end else begin
      dout_q      <= dout_d;
      dout_en_q   <= dout_en_d;
      dout_addr_q <= dout_addr_d;
      ptr_q       <= ptr_d;
    end
  end

  assign dout      = dout_q;
  assign dout_en   = dout_en_q;
  assign dout_addr = dout_addr_q;

endmodule

// File: tb/tb_router_merge.sv
// Directed bench for router_merge: a vector table plus hand-written multi-cycle sequences.
// Expectations follow the build: round-robin when ROUTER_MERGE_RR_EN is defined, fixed priority otherwise.
module tb_router_merge;

  logic        clk;
  logic        resetn;
  logic [31:0] din0, din1, din2, din3;
  logic        din_en0, din_en1, din_en2, din_en3;
  logic        din_ready0, din_ready1, din_ready2, din_ready3;
  logic [31:0] dout;
  logic        dout_en;
  logic [1:0]  dout_addr;
  logic        dout_ready;

  int passCount;
  int totalCount;

  router_merge #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din0       (din0),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
    .din_en0    (din_en0),
    .din_en1    (din_en1),
    .din_en2    (din_en2),
    .din_en3    (din_en3),
    .din_ready0 (din_ready0),
    .din_ready1 (din_ready1),
    .din_ready2 (din_ready2),
    .din_ready3 (din_ready3),
    .dout       (dout),
    .dout_en    (dout_en),
    .dout_addr  (dout_addr),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  en;
    logic [31:0] d;
    logic        rdy;
    logic [3:0]  expReady;
    logic [31:0] expDout;
    logic        expEn;
    logic [1:0]  expAddr;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [3:0] readyVec();
    return {din_ready3, din_ready2, din_ready1, din_ready0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      passCount++;
    end
  endtask

  // Source N always sees d+N so every beat identifies where it came from.
  task automatic setInputs(input logic [3:0] en, input logic [31:0] d, input logic rdy);
    din0       = d;
    din1       = d + 32'd1;
    din2       = d + 32'd2;
    din3       = d + 32'd3;
    din_en0    = en[0];
    din_en1    = en[1];
    din_en2    = en[2];
    din_en3    = en[3];
    dout_ready = rdy;
  endtask

  task automatic applyStimulus(input string name, input logic [3:0] en, input logic [31:0] d,
                               input logic rdy, input logic [3:0] expReady, input logic [31:0] expDout,
                               input logic expEn, input logic [1:0] expAddr);
    @(negedge clk);
    setInputs(en, d, rdy);
    #1;
    checkOutput({name, " ready"}, {28'd0, readyVec()}, {28'd0, expReady});
    @(posedge clk);
    #1;
    checkOutput({name, " dout"}, dout, expDout);
    checkOutput({name, " dout_en"}, {31'd0, dout_en}, {31'd0, expEn});
    checkOutput({name, " dout_addr"}, {30'd0, dout_addr}, {30'd0, expAddr});
  endtask

  task automatic doReset();
    @(negedge clk);
    resetn = 1'b0;
    setInputs(4'b0000, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  logic [1:0] contAddr [5];

  initial begin
    passCount  = 0;
    totalCount = 0;

    // Entries 6 and 7 resolve identically under round-robin and fixed priority.
    vecs[0] = '{4'b0100, 32'hA5A5A5A3, 1'b1, 4'b0100, 32'hA5A5A5A5, 1'b1, 2'd2};
    vecs[1] = '{4'b0000, 32'h0,        1'b1, 4'b0000, 32'h0,        1'b0, 2'd0};
    vecs[2] = '{4'b0010, 32'h10,       1'b0, 4'b0010, 32'h11,       1'b1, 2'd1};
    vecs[3] = '{4'b0001, 32'h20,       1'b0, 4'b0000, 32'h11,       1'b1, 2'd1};
    vecs[4] = '{4'b1000, 32'h30,       1'b1, 4'b1000, 32'h33,       1'b1, 2'd3};
    vecs[5] = '{4'b1001, 32'h40,       1'b1, 4'b0001, 32'h40,       1'b1, 2'd0};
    vecs[6] = '{4'b0110, 32'h50,       1'b1, 4'b0010, 32'h51,       1'b1, 2'd1};
    vecs[7] = '{4'b0000, 32'h60,       1'b0, 4'b0000, 32'h51,       1'b1, 2'd1};
    vecs[8] = '{4'b0000, 32'h70,       1'b1, 4'b0000, 32'h0,        1'b0, 2'd0};

`ifdef ROUTER_MERGE_RR_EN
    contAddr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    contAddr = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

    resetn = 1'b0;
    setInputs(4'b1111, 32'hDEAD0000, 1'b0);
    #3;
    checkOutput("reset dout", dout, 32'h0);
    checkOutput("reset dout_en", {31'd0, dout_en}, 32'h0);
    checkOutput("reset dout_addr", {30'd0, dout_addr}, 32'h0);
    checkOutput("reset ready", {28'd0, readyVec()}, 32'h0);
    doReset();

    for (int i = 0; i < 9; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].en, vecs[i].d, vecs[i].rdy,
                    vecs[i].expReady, vecs[i].expDout, vecs[i].expEn, vecs[i].expAddr);
    end

    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("contend%0d", i), 4'b1111, 32'h100, 1'b1,
                    4'b0001 << contAddr[i], 32'h100 + {30'd0, contAddr[i]}, 1'b1, contAddr[i]);
    end

    doReset();
    applyStimulus("bp load", 4'b0001, 32'h1, 1'b1, 4'b0001, 32'h1, 1'b1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("bp hold%0d", i), 4'b0010, 32'h200, 1'b0, 4'b0000, 32'h1, 1'b1, 2'd0);
    end
    applyStimulus("bp release", 4'b0010, 32'h200, 1'b1, 4'b0010, 32'h201, 1'b1, 2'd1);
    applyStimulus("bp drain", 4'b0000, 32'h200, 1'b1, 4'b0000, 32'h0, 1'b0, 2'd0);

    doReset();
    applyStimulus("wrap src3", 4'b1000, 32'h300, 1'b1, 4'b1000, 32'h303, 1'b1, 2'd3);
    applyStimulus("wrap src0", 4'b1001, 32'h310, 1'b1, 4'b0001, 32'h310, 1'b1, 2'd0);

    doReset();
    applyStimulus("mid load", 4'b0010, 32'h400, 1'b1, 4'b0010, 32'h401, 1'b1, 2'd1);
    applyStimulus("mid hold", 4'b0000, 32'h400, 1'b0, 4'b0000, 32'h401, 1'b1, 2'd1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    setInputs(4'b1111, 32'h400, 1'b1);
    #1;
    checkOutput("mid rst dout", dout, 32'h0);
    checkOutput("mid rst dout_en", {31'd0, dout_en}, 32'h0);
    checkOutput("mid rst dout_addr", {30'd0, dout_addr}, 32'h0);
    checkOutput("mid rst ready", {28'd0, readyVec()}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("post rst ready", {28'd0, readyVec()}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("post rst dout", dout, 32'h400);
    checkOutput("post rst dout_en", {31'd0, dout_en}, 32'h1);
    checkOutput("post rst dout_addr", {30'd0, dout_addr}, 32'h0);

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
